// File: rtl/dcache_snoop_store.sv
// rtl/dcache_snoop_store.sv - D-cache tag/status arrays with snoop read ports and snoop request FIFO (optional DCSTORE_OVERFLOW_EN adds o_q_overflow)
module dcache_snoop_store #(
    parameter int LINE_AW = 7,
    parameter int TAG_W   = 21,
    parameter int Q_W     = 32,
    parameter int Q_AW    = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [LINE_AW-1:0] i_line_a,
    input  logic [LINE_AW-1:0] i_snoop_a,
    input  logic               i_tag_we,
    input  logic [TAG_W-1:0]   i_tag_d,
    output logic [TAG_W-1:0]   o_tag_spo,
    output logic [TAG_W-1:0]   o_tag_dpo,
    input  logic               i_stat_we,
    input  logic [1:0]         i_stat_d,
    output logic [1:0]         o_stat_spo,
    output logic [1:0]         o_stat_dpo,
    input  logic [Q_W-1:0]     i_q_din,
    input  logic               i_q_wr_en,
    input  logic               i_q_rd_en,
    output logic [Q_W-1:0]     o_q_dout,
    output logic               o_q_full,
    output logic               o_q_empty,
    output logic               o_q_almost_empty
`ifdef DCSTORE_OVERFLOW_EN
    ,
    output logic               o_q_overflow
`endif
);

    localparam int              LINES    = 2 ** LINE_AW;
    localparam int              DEPTH    = 2 ** Q_AW;
    localparam logic [Q_AW:0]   FULL_CNT = (Q_AW + 1)'(DEPTH);
    localparam logic [Q_AW:0]   ONE_CNT  = (Q_AW + 1)'(1);

    // Array storage is deliberately outside reset: the controller rewrites it during setup
    logic [TAG_W-1:0] r_tag  [0:LINES-1];
    logic [1:0]       r_stat [0:LINES-1];

    logic [Q_W-1:0]   r_mem  [0:DEPTH-1];
    logic [Q_AW-1:0]  r_wr_ptr;
    logic [Q_AW-1:0]  r_rd_ptr;
    logic [Q_AW:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Tag array write port; reads below are asynchronous so a write shows only after the edge
    always_ff @(posedge i_clock) begin
        if (i_tag_we) begin
            r_tag[i_line_a] <= i_tag_d;
        end
    end

    // Status array write port, independent of the tag write enable
    always_ff @(posedge i_clock) begin
        if (i_stat_we) begin
            r_stat[i_line_a] <= i_stat_d;
        end
    end

    assign o_tag_spo  = r_tag[i_line_a];
    assign o_tag_dpo  = r_tag[i_snoop_a];
    assign o_stat_spo = r_stat[i_line_a];
    assign o_stat_dpo = r_stat[i_snoop_a];

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push
    assign w_push  = i_q_wr_en & (~w_full | i_q_rd_en);
    assign w_pop   = i_q_rd_en & ~w_empty;

    // Queue word storage, written at the tail; no reset needed since count gates visibility
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_q_din;
        end
    end

    // Pointers wrap naturally at Q_AW bits; count tracks occupancy for the flags
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_q_dout         = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_q_full         = w_full;
    assign o_q_empty        = w_empty;
    assign o_q_almost_empty = (r_count <= ONE_CNT);

`ifdef DCSTORE_OVERFLOW_EN
    logic r_overflow;

    // Sticky record of any push dropped because the FIFO was full and not draining
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (i_q_wr_en && w_full && !i_q_rd_en) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_q_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_dcache_snoop_store.sv
// tb/tb_dcache_snoop_store.sv - self-checking bench for dcache_snoop_store
module tb_dcache_snoop_store;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  line_a, snoop_a;
    logic        tag_we, stat_we;
    logic [20:0] tag_d, tag_spo, tag_dpo;
    logic [1:0]  stat_d, stat_spo, stat_dpo;
    logic [31:0] q_din, q_dout;
    logic        q_wr_en, q_rd_en, q_full, q_empty, q_almost_empty;
`ifdef DCSTORE_OVERFLOW_EN
    logic        q_overflow;
`endif

    always #5 clk = ~clk;

    dcache_snoop_store dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_line_a         (line_a),
        .i_snoop_a        (snoop_a),
        .i_tag_we         (tag_we),
        .i_tag_d          (tag_d),
        .o_tag_spo        (tag_spo),
        .o_tag_dpo        (tag_dpo),
        .i_stat_we        (stat_we),
        .i_stat_d         (stat_d),
        .o_stat_spo       (stat_spo),
        .o_stat_dpo       (stat_dpo),
        .i_q_din          (q_din),
        .i_q_wr_en        (q_wr_en),
        .i_q_rd_en        (q_rd_en),
        .o_q_dout         (q_dout),
        .o_q_full         (q_full),
        .o_q_empty        (q_empty),
        .o_q_almost_empty (q_almost_empty)
`ifdef DCSTORE_OVERFLOW_EN
        ,
        .o_q_overflow     (q_overflow)
`endif
    );

    typedef struct {
        logic        we_t;
        logic        we_s;
        logic [6:0]  line;
        logic [6:0]  snoop;
        logic [20:0] td;
        logic [1:0]  sd;
        logic [20:0] pre_tag_spo;
        logic [20:0] post_tag_spo;
        logic [20:0] post_tag_dpo;
        logic [1:0]  post_stat_spo;
        logic [1:0]  post_stat_dpo;
    } vec_t;

    vec_t        vecs[5];
    int          errors = 0;
    int          checks = 0;
    logic [20:0] m_tag[128];
    logic [1:0]  m_stat[128];
    logic [31:0] m_q[$];
    bit          m_ovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_op(input bit wr, input bit rd, input logic [31:0] d);
        q_wr_en = wr;
        q_rd_en = rd;
        q_din   = d;
        tick();
        q_wr_en = 1'b0;
        q_rd_en = 1'b0;
    endtask

    task automatic chk_q(input string nm, input logic [31:0] dout, input bit empty,
                         input bit aempty, input bit full);
        chk({nm, ".dout"}, q_dout, dout);
        chk({nm, ".empty"}, {31'b0, q_empty}, {31'b0, empty});
        chk({nm, ".aempty"}, {31'b0, q_almost_empty}, {31'b0, aempty});
        chk({nm, ".full"}, {31'b0, q_full}, {31'b0, full});
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 7'd5,   7'd5,   21'h1ABCD,  2'd0, 21'h0,     21'h1ABCD,  21'h1ABCD, 2'd0, 2'd0};
        vecs[1] = '{1'b0, 1'b1, 7'd127, 7'd127, 21'h1FFFFF, 2'd3, 21'h0,     21'h0,      21'h0,     2'd3, 2'd3};
        vecs[2] = '{1'b1, 1'b1, 7'd127, 7'd5,   21'h00042,  2'd2, 21'h0,     21'h00042,  21'h1ABCD, 2'd2, 2'd0};
        vecs[3] = '{1'b0, 1'b0, 7'd5,   7'd127, 21'h155555, 2'd1, 21'h1ABCD, 21'h1ABCD,  21'h00042, 2'd0, 2'd2};
        vecs[4] = '{1'b1, 1'b0, 7'd0,   7'd127, 21'h1FFFFF, 2'd0, 21'h0,     21'h1FFFFF, 21'h00042, 2'd0, 2'd2};

        rst = 1'b1;
        line_a = '0; snoop_a = '0; tag_we = 0; stat_we = 0; tag_d = '0; stat_d = '0;
        q_din = '0; q_wr_en = 0; q_rd_en = 0;
        m_ovf = 0;
        tick();
        tick();
        chk_q("reset", 32'h0, 1, 1, 0);
        rst = 1'b0;

        // Setup sequence: clear both arrays
        for (int i = 0; i < 128; i++) begin
            line_a = 7'(i); tag_we = 1; stat_we = 1; tag_d = '0; stat_d = '0;
            tick();
            m_tag[i] = '0; m_stat[i] = '0;
        end
        tag_we = 0; stat_we = 0;

        // Array vectors: old data during the write cycle, new data after the edge
        for (int i = 0; i < 5; i++) begin
            line_a = vecs[i].line; snoop_a = vecs[i].snoop;
            tag_we = vecs[i].we_t; stat_we = vecs[i].we_s;
            tag_d = vecs[i].td; stat_d = vecs[i].sd;
            #1;
            chk($sformatf("vec%0d.pre_tag_spo", i), {11'b0, tag_spo}, {11'b0, vecs[i].pre_tag_spo});
            tick();
            tag_we = 0; stat_we = 0;
            if (vecs[i].we_t) m_tag[vecs[i].line] = vecs[i].td;
            if (vecs[i].we_s) m_stat[vecs[i].line] = vecs[i].sd;
            chk($sformatf("vec%0d.tag_spo", i), {11'b0, tag_spo}, {11'b0, vecs[i].post_tag_spo});
            chk($sformatf("vec%0d.tag_dpo", i), {11'b0, tag_dpo}, {11'b0, vecs[i].post_tag_dpo});
            chk($sformatf("vec%0d.stat_spo", i), {30'b0, stat_spo}, {30'b0, vecs[i].post_stat_spo});
            chk($sformatf("vec%0d.stat_dpo", i), {30'b0, stat_dpo}, {30'b0, vecs[i].post_stat_dpo});
        end

        // FIFO order and flags
        fifo_op(1, 0, 32'h1000_0001);
        chk_q("push1", 32'h1000_0001, 0, 1, 0);
        fifo_op(1, 0, 32'h1000_0002);
        fifo_op(1, 0, 32'h1000_0003);
        chk_q("push3", 32'h1000_0001, 0, 0, 0);
        fifo_op(0, 1, 32'h0);
        chk_q("pop1", 32'h1000_0002, 0, 0, 0);
        fifo_op(0, 1, 32'h0);
        chk_q("pop2", 32'h1000_0003, 0, 1, 0);
        fifo_op(0, 1, 32'h0);
        chk_q("pop3", 32'h0, 1, 1, 0);
        fifo_op(0, 1, 32'h0);
        chk_q("pop_empty", 32'h0, 1, 1, 0);

        // Fill to 16, then a dropped 17th push
        for (int i = 1; i <= 16; i++) fifo_op(1, 0, 32'h2000_0000 + 32'(i));
        chk_q("full16", 32'h2000_0001, 0, 0, 1);
`ifdef DCSTORE_OVERFLOW_EN
        chk("ovf_before", {31'b0, q_overflow}, 32'h0);
`endif
        fifo_op(1, 0, 32'h2000_0011);
        chk_q("push17", 32'h2000_0001, 0, 0, 1);
`ifdef DCSTORE_OVERFLOW_EN
        chk("ovf_after", {31'b0, q_overflow}, 32'h1);
`endif
        // Push+pop while full: stays full, head advances
        fifo_op(1, 1, 32'h0000_AAAA);
        chk_q("pushpop_full", 32'h2000_0002, 0, 0, 1);
        for (int i = 2; i <= 16; i++) begin
            chk($sformatf("drain%0d", i), q_dout, 32'h2000_0000 + 32'(i));
            fifo_op(0, 1, 32'h0);
        end
        chk_q("drain_last", 32'h0000_AAAA, 0, 1, 0);
        fifo_op(0, 1, 32'h0);
        chk_q("drained", 32'h0, 1, 1, 0);

        // Push+pop while empty: only the push lands
        fifo_op(1, 1, 32'h3000_0001);
        chk_q("pushpop_empty", 32'h3000_0001, 0, 1, 0);
        fifo_op(0, 1, 32'h0);
        chk_q("pushpop_empty_pop", 32'h0, 1, 1, 0);

        // Async reset with 5 queued words, observed before the next edge
        for (int i = 0; i < 5; i++) fifo_op(1, 0, 32'h4000_0000 + 32'(i));
        chk_q("five_queued", 32'h4000_0000, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_q("async_reset", 32'h0, 1, 1, 0);
`ifdef DCSTORE_OVERFLOW_EN
        chk("ovf_reset", {31'b0, q_overflow}, 32'h0);
`endif
        line_a = 7'd127; snoop_a = 7'd5;
        #1;
        chk("reset_keeps_tag", {11'b0, tag_dpo}, {11'b0, 21'h1ABCD});
        chk("reset_keeps_stat", {30'b0, stat_spo}, 32'h2);
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic against the queue/array model
        m_q.delete();
        m_ovf = 0;
        for (int c = 0; c < 800; c++) begin
            bit wr, rd, push_ok, pop_ok;
            int wr_pct;
            wr_pct = ((c / 100) % 2 == 0) ? 75 : 30;
            wr = ($urandom_range(99) < wr_pct);
            rd = ($urandom_range(99) >= wr_pct);
            line_a  = 7'($urandom_range(127));
            snoop_a = 7'($urandom_range(127));
            tag_we  = ($urandom_range(3) == 0);
            stat_we = ($urandom_range(3) == 0);
            tag_d   = 21'($urandom);
            stat_d  = 2'($urandom);
            q_din   = $urandom;
            q_wr_en = wr;
            q_rd_en = rd;
            push_ok = wr && (m_q.size() < 16 || rd);
            pop_ok  = rd && (m_q.size() > 0);
            if (wr && m_q.size() == 16 && !rd) m_ovf = 1;
            if (pop_ok) void'(m_q.pop_front());
            if (push_ok) m_q.push_back(q_din);
            if (tag_we) m_tag[line_a] = tag_d;
            if (stat_we) m_stat[line_a] = stat_d;
            tick();
            chk("rnd.dout", q_dout, (m_q.size() == 0) ? 32'h0 : m_q[0]);
            chk("rnd.empty", {31'b0, q_empty}, {31'b0, m_q.size() == 0});
            chk("rnd.aempty", {31'b0, q_almost_empty}, {31'b0, m_q.size() <= 1});
            chk("rnd.full", {31'b0, q_full}, {31'b0, m_q.size() == 16});
            chk("rnd.tag_spo", {11'b0, tag_spo}, {11'b0, m_tag[line_a]});
            chk("rnd.tag_dpo", {11'b0, tag_dpo}, {11'b0, m_tag[snoop_a]});
            chk("rnd.stat_spo", {30'b0, stat_spo}, {30'b0, m_stat[line_a]});
            chk("rnd.stat_dpo", {30'b0, stat_dpo}, {30'b0, m_stat[snoop_a]});
`ifdef DCSTORE_OVERFLOW_EN
            chk("rnd.ovf", {31'b0, q_overflow}, {31'b0, m_ovf});
`endif
        end
        q_wr_en = 0; q_rd_en = 0; tag_we = 0; stat_we = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
